// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin front end that shares one combinational 4-bit ALU
// between two requesters. One operation in flight: accept, hold the ALU inputs
// for SETTLE cycles, capture the ALU outputs, then hand the result back.
module alu_arbiter #(
  parameter int SETTLE = 1,  // cycles the ALU inputs are held before sampling (1..15)
  parameter int CNT_W  = 8   // width of the completed-operation counter
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [3:0]       req0_a,
  input  logic [3:0]       req0_b,
  input  logic [2:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [3:0]       req1_a,
  input  logic [3:0]       req1_b,
  input  logic [2:0]       req1_op,
  output logic [3:0]       alu_a,
  output logic [3:0]       alu_b,
  output logic [2:0]       alu_ctrl,
  input  logic [3:0]       alu_res,
  input  logic             alu_car,
  input  logic             alu_of,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [3:0]       rsp_res,
  output logic             rsp_car,
  output logic             rsp_of,
  output logic             busy,
  output logic [CNT_W-1:0] op_cnt
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t      state_reg, state_next;
  logic        rr_reg;          // favoured requester
  logic [3:0]  a_reg, b_reg;
  logic [2:0]  op_reg;
  logic        id_reg;
  logic [3:0]  settle_cnt_reg;
  logic [3:0]  rsp_res_reg;
  logic        rsp_car_reg, rsp_of_reg, rsp_id_reg;
  logic [CNT_W-1:0] op_cnt_reg;

  logic        any_valid;
  logic        grant_id;
  logic        accept;
  logic        settle_done;
  logic        handshake;

  // Pick the favoured requester if it is asking, otherwise the other one.
  always_comb begin
    any_valid = req0_valid | req1_valid;
    if (rr_reg) grant_id = req1_valid ? 1'b1 : 1'b0;
    else        grant_id = req0_valid ? 1'b0 : 1'b1;
  end

  // Next-state and handshake decode; readies only ever asserted in IDLE.
  always_comb begin
    state_next  = state_reg;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    accept      = 1'b0;
    settle_done = 1'b0;
    handshake   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (any_valid) begin
          accept     = 1'b1;
          req0_ready = ~grant_id;
          req1_ready = grant_id;
          state_next = EXEC;
        end
      end
      EXEC: begin
        if (settle_cnt_reg == 4'(SETTLE - 1)) begin
          settle_done = 1'b1;
          state_next  = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          handshake  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Operation latch and settle counter; the latch is written only on accept
  // so the ALU inputs stay constant for the whole of EXEC and RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg          <= '0;
      b_reg          <= '0;
      op_reg         <= '0;
      id_reg         <= 1'b0;
      settle_cnt_reg <= '0;
    end else if (accept) begin
      a_reg          <= grant_id ? req1_a  : req0_a;
      b_reg          <= grant_id ? req1_b  : req0_b;
      op_reg         <= grant_id ? req1_op : req0_op;
      id_reg         <= grant_id;
      settle_cnt_reg <= '0;
    end else if (state_reg == EXEC && !settle_done) begin
      settle_cnt_reg <= settle_cnt_reg + 4'd1;
    end
  end

  // Result capture at the end of the settle window; held until the next capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_res_reg <= '0;
      rsp_car_reg <= 1'b0;
      rsp_of_reg  <= 1'b0;
      rsp_id_reg  <= 1'b0;
    end else if (settle_done) begin
      rsp_res_reg <= alu_res;
      rsp_car_reg <= alu_car;
      rsp_of_reg  <= alu_of;
      rsp_id_reg  <= id_reg;
    end
  end

  // Completion counter and round-robin pointer advance on the response handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_cnt_reg <= '0;
      rr_reg     <= 1'b0;
    end else if (handshake) begin
      op_cnt_reg <= op_cnt_reg + 1'b1;
      rr_reg     <= ~rsp_id_reg;
    end
  end

  assign alu_a     = (state_reg == IDLE) ? 4'd0 : a_reg;
  assign alu_b     = (state_reg == IDLE) ? 4'd0 : b_reg;
  assign alu_ctrl  = (state_reg == IDLE) ? 3'd0 : op_reg;
  assign rsp_valid = (state_reg == RESP);
  assign busy      = (state_reg != IDLE);
  assign rsp_id    = rsp_id_reg;
  assign rsp_res   = rsp_res_reg;
  assign rsp_car   = rsp_car_reg;
  assign rsp_of    = rsp_of_reg;
  assign op_cnt    = op_cnt_reg;

endmodule
